// File: rtl/psg_pkg.sv
// Shared types and constants for the SN76489-style PSG register file.
// Imported by the bus capture stage and the register file body.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        COMMIT
    } psg_bus_state_t;

    localparam logic [3:0] ATTEN_SILENT = 4'hF;
    localparam logic [1:0] NOISE_CH     = 2'd3;
    localparam logic [2:0] REG_NOISE    = 3'd6;

endpackage

// File: rtl/psg_bus_capture.sv
// Snoops Z80 I/O writes inside a port window and holds the last byte written.
// Emits a one-cycle commit indication once the write strobe goes away.
module psg_bus_capture
    import psg_pkg::*;
#(
    parameter logic [7:0] PORT_LO = 8'h40,
    parameter logic [7:0] PORT_HI = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_addr,
    input  logic       i_mreqN,
    input  logic       i_wrN,
    input  logic [7:0] i_data,
    output logic [7:0] o_byte,
    output logic       o_commit
);

    psg_bus_state_t r_state;
    psg_bus_state_t w_nextState;
    logic [7:0]     r_byte;
    logic           w_hit;

    assign w_hit = (i_addr >= PORT_LO) && (i_addr <= PORT_HI) && !i_mreqN && !i_wrN;

    // Sampling on every hit cycle makes the last bus value win, including a one-cycle glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_nextState;
            if (w_hit) begin
                r_byte <= i_data;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_hit)  w_nextState = CAPTURE;
            CAPTURE: if (!w_hit) w_nextState = COMMIT;
            COMMIT:  w_nextState = w_hit ? CAPTURE : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign o_byte   = r_byte;
    assign o_commit = (r_state == COMMIT);

endmodule

// File: rtl/psg_reg_file.sv
// PSG register file: decodes SN76489 latch/data bytes into tone, attenuation
// and noise registers, with registered one-cycle write strobes per register.
module psg_reg_file
    import psg_pkg::*;
#(
    parameter int         NUM_TONE = 3,
    parameter int         FREQ_W   = 10,
    parameter int         ATTEN_W  = 4,
    parameter logic [7:0] PORT_LO  = 8'h40,
    parameter logic [7:0] PORT_HI  = 8'h7F
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [15:0]                     addr,
    input  logic                            MREQ_N,
    input  logic                            WR_N,
    input  logic [7:0]                      data,
    output logic [NUM_TONE*FREQ_W-1:0]      tone_freq,
    output logic [(NUM_TONE+1)*ATTEN_W-1:0] atten,
    output logic [2:0]                      noise_ctrl,
    output logic [NUM_TONE-1:0]             tone_wr,
    output logic [NUM_TONE:0]               atten_wr,
    output logic                            noise_wr
);

    logic [7:0]         w_byte;
    logic               w_commit;
    logic               w_unusedAddr;
    logic               w_isLatch;
    logic [2:0]         w_reg;
    logic [1:0]         w_ch;
    logic               w_isNoise;
    logic [23:0]        w_byteExt;
    logic [NUM_TONE-1:0] w_toneSel;
    logic [NUM_TONE:0]  w_attenSel;

    logic [2:0]         r_latched;
    logic [FREQ_W-1:0]  r_tone [NUM_TONE];
    logic [ATTEN_W-1:0] r_atten [NUM_TONE+1];
    logic [2:0]         r_noise;
    logic [NUM_TONE-1:0] r_toneWr;
    logic [NUM_TONE:0]  r_attenWr;
    logic               r_noiseWr;

    psg_bus_capture #(
        .PORT_LO (PORT_LO),
        .PORT_HI (PORT_HI)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .i_addr   (addr[7:0]),
        .i_mreqN  (MREQ_N),
        .i_wrN    (WR_N),
        .i_data   (data),
        .o_byte   (w_byte),
        .o_commit (w_commit)
    );

    assign w_unusedAddr = ^addr[15:8];

    // Data bytes reuse the register selected by the most recent latch byte.
    assign w_isLatch = w_byte[7];
    assign w_reg     = w_isLatch ? w_byte[6:4] : r_latched;
    assign w_ch      = w_reg[2:1];
    assign w_isNoise = (w_reg == REG_NOISE);
    assign w_byteExt = {16'h0000, w_byte};

    // Channels beyond NUM_TONE select nothing; the top atten slot belongs to noise.
    always_comb begin
        w_toneSel  = '0;
        w_attenSel = '0;
        for (int i = 0; i < NUM_TONE; i++) begin
            w_toneSel[i] = !w_reg[0] && (w_ch == 2'(i));
        end
        for (int i = 0; i <= NUM_TONE; i++) begin
            w_attenSel[i] = w_reg[0] && ((i == NUM_TONE) ? (w_ch == NOISE_CH) : (w_ch == 2'(i)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latched <= 3'd0;
            r_noise   <= 3'd0;
            r_toneWr  <= '0;
            r_attenWr <= '0;
            r_noiseWr <= 1'b0;
            for (int i = 0; i < NUM_TONE; i++) begin
                r_tone[i] <= '0;
            end
            for (int i = 0; i <= NUM_TONE; i++) begin
                r_atten[i] <= ATTEN_W'(ATTEN_SILENT);
            end
        end else begin
            r_toneWr  <= '0;
            r_attenWr <= '0;
            r_noiseWr <= 1'b0;
            if (w_commit) begin
                if (w_isLatch) begin
                    r_latched <= w_byte[6:4];
                end
                if (w_isNoise) begin
                    r_noise   <= w_byte[2:0];
                    r_noiseWr <= 1'b1;
                end
                for (int i = 0; i < NUM_TONE; i++) begin
                    if (w_toneSel[i]) begin
                        if (w_isLatch) begin
                            r_tone[i][3:0] <= w_byte[3:0];
                        end else begin
                            r_tone[i][FREQ_W-1:4] <= w_byteExt[FREQ_W-5:0];
                        end
                        r_toneWr[i] <= 1'b1;
                    end
                end
                for (int i = 0; i <= NUM_TONE; i++) begin
                    if (w_attenSel[i]) begin
                        r_atten[i]   <= ATTEN_W'(w_byte[3:0]);
                        r_attenWr[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        tone_freq = '0;
        atten     = '0;
        for (int i = 0; i < NUM_TONE; i++) begin
            tone_freq[i*FREQ_W +: FREQ_W] = r_tone[i];
        end
        for (int i = 0; i <= NUM_TONE; i++) begin
            atten[i*ATTEN_W +: ATTEN_W] = r_atten[i];
        end
    end

    assign noise_ctrl = r_noise;
    assign tone_wr    = r_toneWr;
    assign atten_wr   = r_attenWr;
    assign noise_wr   = r_noiseWr;

endmodule

// File: tb/tb_psg_reg_file.sv
// Self-checking bench for psg_reg_file: a table of bus writes with expected
// register state, a strobe scoreboard, and hand sequences for corner cases.
module tb_psg_reg_file;

    typedef struct {
        int          cyc;
        logic [29:0] tone;
        logic [15:0] atten;
        logic [2:0]  noise;
        logic [2:0]  toneWr;
        logic [3:0]  attenWr;
        logic        noiseWr;
    } sb_t;

    typedef struct {
        logic [15:0] a;
        logic        mreqN;
        logic [7:0]  d;
        int          len;
        logic        stb;
        logic [29:0] tone;
        logic [15:0] atten;
        logic [2:0]  noise;
        logic [2:0]  toneWr;
        logic [3:0]  attenWr;
        logic        noiseWr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        MREQ_N = 1'b1;
    logic        WR_N = 1'b1;
    logic [7:0]  data = 8'h00;

    logic [29:0] tone_freq;
    logic [15:0] atten;
    logic [2:0]  noise_ctrl;
    logic [2:0]  tone_wr;
    logic [3:0]  atten_wr;
    logic        noise_wr;

    logic [19:0] tone_freq2;
    logic [11:0] atten2;
    logic [2:0]  noise_ctrl2;
    logic [1:0]  tone_wr2;
    logic [2:0]  atten_wr2;
    logic        noise_wr2;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    sb_t sbQ[$];
    sb_t e;
    vec_t vecs[14];

    psg_reg_file dut (
        .clk(clk), .reset(reset), .addr(addr), .MREQ_N(MREQ_N), .WR_N(WR_N), .data(data),
        .tone_freq(tone_freq), .atten(atten), .noise_ctrl(noise_ctrl),
        .tone_wr(tone_wr), .atten_wr(atten_wr), .noise_wr(noise_wr)
    );

    psg_reg_file #(.NUM_TONE(2)) dut2 (
        .clk(clk), .reset(reset), .addr(addr), .MREQ_N(MREQ_N), .WR_N(WR_N), .data(data),
        .tone_freq(tone_freq2), .atten(atten2), .noise_ctrl(noise_ctrl2),
        .tone_wr(tone_wr2), .atten_wr(atten_wr2), .noise_wr(noise_wr2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sb_t mkRec(input logic [29:0] tone, input logic [15:0] at, input logic [2:0] nz,
                                  input logic [2:0] tw, input logic [3:0] aw, input logic nw);
        sb_t r;
        r.cyc = 0; r.tone = tone; r.atten = at; r.noise = nz;
        r.toneWr = tw; r.attenWr = aw; r.noiseWr = nw;
        return r;
    endfunction

    // Each strobe seen on the NUM_TONE=3 instance must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
                checkVal("strobe_missing_at_cycle", 64'(cyc), 64'(sbQ[0].cyc));
                void'(sbQ.pop_front());
            end
            if (tone_wr != 3'b0 || atten_wr != 4'b0 || noise_wr) begin
                if (sbQ.size() == 0) begin
                    checkVal("strobe_unexpected", 64'({tone_wr, atten_wr, noise_wr}), 64'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkVal("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    checkVal("tone_wr", 64'(tone_wr), 64'(e.toneWr));
                    checkVal("atten_wr", 64'(atten_wr), 64'(e.attenWr));
                    checkVal("noise_wr", 64'(noise_wr), 64'(e.noiseWr));
                    checkVal("sb_tone_freq", 64'(tone_freq), 64'(e.tone));
                    checkVal("sb_atten", 64'(atten), 64'(e.atten));
                    checkVal("sb_noise_ctrl", 64'(noise_ctrl), 64'(e.noise));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic mreqN, input logic [7:0] d,
                                 input int len, input logic stb, input sb_t expRec);
        sb_t r;
        @(negedge clk);
        addr = a; data = d; MREQ_N = mreqN; WR_N = 1'b0;
        if (stb) begin
            r = expRec;
            r.cyc = cyc + len + 2;
            sbQ.push_back(r);
        end
        repeat (len) @(negedge clk);
        MREQ_N = 1'b1; WR_N = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [29:0] tone, input logic [15:0] at,
                               input logic [2:0] nz);
        checkVal({name, "_tone_freq"}, 64'(tone_freq), 64'(tone));
        checkVal({name, "_atten"}, 64'(atten), 64'(at));
        checkVal({name, "_noise_ctrl"}, 64'(noise_ctrl), 64'(nz));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{16'h007F, 1'b0, 8'h80, 1, 1'b1, 30'h0,     16'hFFFF, 3'd0, 3'b001, 4'b0000, 1'b0};
        vecs[1]  = '{16'h007F, 1'b0, 8'h3F, 1, 1'b1, 30'h3F0,   16'hFFFF, 3'd0, 3'b001, 4'b0000, 1'b0};
        vecs[2]  = '{16'h0040, 1'b0, 8'hD5, 2, 1'b1, 30'h3F0,   16'hF5FF, 3'd0, 3'b000, 4'b0100, 1'b0};
        vecs[3]  = '{16'h0055, 1'b0, 8'h0A, 1, 1'b1, 30'h3F0,   16'hFAFF, 3'd0, 3'b000, 4'b0100, 1'b0};
        vecs[4]  = '{16'h0060, 1'b0, 8'h03, 3, 1'b1, 30'h3F0,   16'hF3FF, 3'd0, 3'b000, 4'b0100, 1'b0};
        vecs[5]  = '{16'h007F, 1'b0, 8'hE4, 1, 1'b1, 30'h3F0,   16'hF3FF, 3'd4, 3'b000, 4'b0000, 1'b1};
        vecs[6]  = '{16'h0041, 1'b0, 8'h01, 1, 1'b1, 30'h3F0,   16'hF3FF, 3'd1, 3'b000, 4'b0000, 1'b1};
        vecs[7]  = '{16'h0040, 1'b0, 8'hF7, 1, 1'b1, 30'h3F0,   16'h73FF, 3'd1, 3'b000, 4'b1000, 1'b0};
        vecs[8]  = '{16'h0040, 1'b0, 8'hAC, 1, 1'b1, 30'h33F0,  16'h73FF, 3'd1, 3'b010, 4'b0000, 1'b0};
        vecs[9]  = '{16'h0040, 1'b0, 8'h15, 2, 1'b1, 30'h573F0, 16'h73FF, 3'd1, 3'b010, 4'b0000, 1'b0};
        vecs[10] = '{16'h003F, 1'b0, 8'h90, 1, 1'b0, 30'h573F0, 16'h73FF, 3'd1, 3'b000, 4'b0000, 1'b0};
        vecs[11] = '{16'h0080, 1'b0, 8'h90, 1, 1'b0, 30'h573F0, 16'h73FF, 3'd1, 3'b000, 4'b0000, 1'b0};
        vecs[12] = '{16'h0050, 1'b1, 8'h90, 1, 1'b0, 30'h573F0, 16'h73FF, 3'd1, 3'b000, 4'b0000, 1'b0};
        vecs[13] = '{16'h0040, 1'b0, 8'hF7, 1, 1'b1, 30'h573F0, 16'h73FF, 3'd1, 3'b000, 4'b1000, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset", 30'h0, 16'hFFFF, 3'd0);
        checkVal("reset_atten_nt2", 64'(atten2), 64'(12'hFFF));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkVal("reset_no_strobe", 64'({tone_wr, atten_wr, noise_wr}), 64'(0));
        end

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a, vecs[i].mreqN, vecs[i].d, vecs[i].len, vecs[i].stb,
                          mkRec(vecs[i].tone, vecs[i].atten, vecs[i].noise,
                                vecs[i].toneWr, vecs[i].attenWr, vecs[i].noiseWr));
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].tone, vecs[i].atten, vecs[i].noise);
        end

        // Back-to-back writes with a single idle cycle between them.
        applyStimulus(16'h0040, 1'b0, 8'h81, 1, 1'b1, mkRec(30'h573F1, 16'h73FF, 3'd1, 3'b001, 4'b0, 1'b0));
        applyStimulus(16'h0040, 1'b0, 8'h02, 1, 1'b1, mkRec(30'h57021, 16'h73FF, 3'd1, 3'b001, 4'b0, 1'b0));
        repeat (4) @(negedge clk);
        checkOutput("b2b", 30'h57021, 16'h73FF, 3'd1);

        // Data changes during a two-cycle hit: the later byte is the one committed.
        @(negedge clk);
        addr = 16'h0040; data = 8'h8F; MREQ_N = 1'b0; WR_N = 1'b0;
        sbQ.push_back(mkRec(30'h57024, 16'h73FF, 3'd1, 3'b001, 4'b0, 1'b0));
        sbQ[$].cyc = cyc + 4;
        @(negedge clk);
        data = 8'h84;
        @(negedge clk);
        MREQ_N = 1'b1; WR_N = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("last_wins", 30'h57024, 16'h73FF, 3'd1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset2", 30'h0, 16'hFFFF, 3'd0);

        // Data byte with no latch since reset lands in tone0 high bits.
        applyStimulus(16'h0040, 1'b0, 8'h05, 1, 1'b1, mkRec(30'h50, 16'hFFFF, 3'd0, 3'b001, 4'b0, 1'b0));
        repeat (3) @(negedge clk);
        checkOutput("data_first", 30'h50, 16'hFFFF, 3'd0);
        checkVal("data_first_nt2", 64'(tone_freq2), 64'(20'h50));

        // Tone channel 2 exists only on the NUM_TONE=3 instance.
        applyStimulus(16'h0040, 1'b0, 8'hC7, 1, 1'b1, mkRec(30'h700050, 16'hFFFF, 3'd0, 3'b100, 4'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("nt2_no_strobe", 64'({tone_wr2, atten_wr2, noise_wr2}), 64'(0));
        end
        checkVal("nt2_tone_freq", 64'(tone_freq2), 64'(20'h50));
        checkOutput("nt3_tone2", 30'h700050, 16'hFFFF, 3'd0);

        // Reset arriving while 0x9F is being captured must drop the write.
        @(negedge clk);
        addr = 16'h0040; data = 8'h9F; MREQ_N = 1'b0; WR_N = 1'b0;
        @(negedge clk);
        reset = 1'b1; MREQ_N = 1'b1; WR_N = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("rst_mid_atten_wr", 64'(atten_wr), 64'(0));
            checkVal("rst_mid_atten_wr_nt2", 64'(atten_wr2), 64'(0));
        end
        checkVal("rst_mid_atten0", 64'(atten[3:0]), 64'(4'hF));
        checkVal("rst_mid_atten0_nt2", 64'(atten2[3:0]), 64'(4'hF));

        checkVal("scoreboard_empty", 64'(sbQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
